// File: rtl/mac_seq_ctrl.sv
// mac_seq_ctrl: sequences a dot product through an external registered mac_unit.
// Reads len operand pairs from the x/w buffers, streams them into the MAC with
// the bias as the seed, waits for the pipeline to drain and holds the result
// until it is accepted.
// Optional feature: define MAC_SEQ_RELU_EN to clamp negative results to zero.
module mac_seq_ctrl #(
  parameter int unsigned N         = 32,
  parameter int unsigned SUM_WIDTH = 2*N+4,
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned LEN_W     = ADDR_W+1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic [LEN_W-1:0]     len_i,
  input  logic [ADDR_W-1:0]    x_base_i,
  input  logic [ADDR_W-1:0]    w_base_i,
  input  logic [SUM_WIDTH-1:0] bias_i,
  output logic                 rd_en_o,
  output logic [ADDR_W-1:0]    x_addr_o,
  output logic [ADDR_W-1:0]    w_addr_o,
  input  logic [N-1:0]         x_data_i,
  input  logic [N-1:0]         w_data_i,
  output logic [N-1:0]         mac_xin_c_o,
  output logic [N-1:0]         mac_win_c_o,
  output logic [SUM_WIDTH-1:0] mac_acc_in_c_o,
  input  logic [SUM_WIDTH-1:0] mac_out_i,
  output logic                 busy_o,
  output logic                 res_valid_o,
  output logic [SUM_WIDTH-1:0] res_data_o,
  input  logic                 res_ready_i
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_e;

  state_e                 state_q, state_d;
  logic [LEN_W-1:0]       cnt_q, cnt_d;
  logic [ADDR_W-1:0]      x_addr_q, x_addr_d;
  logic [ADDR_W-1:0]      w_addr_q, w_addr_d;
  logic                   rd_en_q, rd_en_d;
  logic                   first_rd_q, first_rd_d;
  logic                   dv_q, dv_d;
  logic                   first_dv_q, first_dv_d;
  logic                   drain_q, drain_d;
  logic [SUM_WIDTH-1:0]   bias_q, bias_d;
  logic [SUM_WIDTH-1:0]   res_data_q, res_data_d;
  logic                   busy_q, busy_d;
  logic                   res_valid_q, res_valid_d;
  logic [SUM_WIDTH-1:0]   cap_src, cap_val;

  // Result capture source: bias for the zero-length path, MAC output otherwise.
  always_comb begin
    cap_src = (state_q == IDLE) ? bias_i : mac_out_i;
`ifdef MAC_SEQ_RELU_EN
    cap_val = cap_src[SUM_WIDTH-1] ? '0 : cap_src;
`else
    cap_val = cap_src;
`endif
  end

  // Next-state and register-input logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    x_addr_d    = x_addr_q;
    w_addr_d    = w_addr_q;
    rd_en_d     = rd_en_q;
    first_rd_d  = first_rd_q;
    drain_d     = drain_q;
    bias_d      = bias_q;
    res_data_d  = res_data_q;
    dv_d        = rd_en_q;
    first_dv_d  = rd_en_q & first_rd_q;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          bias_d = bias_i;
          if (len_i != '0) begin
            state_d    = ISSUE;
            cnt_d      = len_i;
            x_addr_d   = x_base_i;
            w_addr_d   = w_base_i;
            rd_en_d    = 1'b1;
            first_rd_d = 1'b1;
          end else begin
            state_d    = DONE;
            res_data_d = cap_val;
          end
        end
      end
      ISSUE: begin
        x_addr_d   = x_addr_q + ADDR_W'(1);
        w_addr_d   = w_addr_q + ADDR_W'(1);
        first_rd_d = 1'b0;
        cnt_d      = cnt_q - LEN_W'(1);
        if (cnt_q == LEN_W'(1)) begin
          rd_en_d = 1'b0;
          drain_d = 1'b0;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        drain_d = 1'b1;
        if (drain_q) begin
          res_data_d = cap_val;
          state_d    = DONE;
        end
      end
      DONE: begin
        if (res_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d      = (state_d != IDLE);
    res_valid_d = (state_d == DONE);
  end

  // State and datapath registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      x_addr_q    <= '0;
      w_addr_q    <= '0;
      rd_en_q     <= 1'b0;
      first_rd_q  <= 1'b0;
      dv_q        <= 1'b0;
      first_dv_q  <= 1'b0;
      drain_q     <= 1'b0;
      bias_q      <= '0;
      res_data_q  <= '0;
      busy_q      <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      x_addr_q    <= x_addr_d;
      w_addr_q    <= w_addr_d;
      rd_en_q     <= rd_en_d;
      first_rd_q  <= first_rd_d;
      dv_q        <= dv_d;
      first_dv_q  <= first_dv_d;
      drain_q     <= drain_d;
      bias_q      <= bias_d;
      res_data_q  <= res_data_d;
      busy_q      <= busy_d;
      res_valid_q <= res_valid_d;
    end
  end

  // MAC operands: feed returning read data, otherwise recirculate to hold.
  always_comb begin
    mac_xin_c_o    = '0;
    mac_win_c_o    = '0;
    mac_acc_in_c_o = mac_out_i;
    if (dv_q) begin
      mac_xin_c_o = x_data_i;
      mac_win_c_o = w_data_i;
      if (first_dv_q) mac_acc_in_c_o = bias_q;
    end
  end

  assign rd_en_o     = rd_en_q;
  assign x_addr_o    = x_addr_q;
  assign w_addr_o    = w_addr_q;
  assign busy_o      = busy_q;
  assign res_valid_o = res_valid_q;
  assign res_data_o  = res_data_q;

endmodule

// File: doc/mac_seq_ctrl.md
MAC_SEQ_CTRL -- requirements
Module: mac_seq_ctrl

Interface
REQ-001 SHALL have parameter N, default 32: operand width of the sequenced mac_unit (signed).
REQ-002 SHALL have parameter SUM_WIDTH, default 68 (2*N+4): accumulator width (signed).
REQ-003 SHALL have parameter ADDR_W, default 8: operand buffer address width.
REQ-004 SHALL have parameter LEN_W, default ADDR_W+1: width of the term-count field.
REQ-005 clk  in  1  sole clock; all state updates on its rising edge.
REQ-006 rst  in  1  asynchronous, active-low reset.
REQ-007 start  in  1  request a dot product; sampled only in IDLE.
REQ-008 len  in  LEN_W  number of product terms; 0..2^ADDR_W.
REQ-009 x_base, w_base  in  ADDR_W each  first input and weight addresses.
REQ-010 bias  in  SUM_WIDTH  initial accumulator value.
REQ-011 rd_en  out  1  buffer read strobe; data returns the next cycle.
REQ-012 x_addr, w_addr  out  ADDR_W each  read addresses, valid when rd_en=1.
REQ-013 x_data, w_data  in  N each  buffer read data, one cycle after rd_en.
REQ-014 mac_xin, mac_win  out  N each; mac_acc_in  out  SUM_WIDTH: mac_unit operands.
REQ-015 mac_out  in  SUM_WIDTH  registered mac_unit result (acc_in + xin*win, 1-cycle latency).
REQ-016 busy  out  1  high in any state other than IDLE.
REQ-017 res_valid  out  1; res_data  out  SUM_WIDTH; res_ready  in  1: result handshake.

Function
REQ-018 SHALL implement FSM states IDLE, ISSUE, DRAIN, DONE.
REQ-019 IDLE with start=1 (cycle 0) SHALL latch len, x_base, w_base and bias; go to ISSUE if len>0, else to DONE with res_data=bias.
REQ-020 ISSUE SHALL assert rd_en for exactly len consecutive cycles, with x_addr=x_base+k and w_addr=w_base+k for k=0..len-1, addresses wrapping modulo 2^ADDR_W; then go to DRAIN.
REQ-021 In the cycle after each read, SHALL drive mac_xin=x_data and mac_win=w_data; mac_acc_in SHALL be the latched bias for term 0 and mac_out for later terms.
REQ-022 In all other cycles, SHALL drive mac_xin=0, mac_win=0 and mac_acc_in=mac_out, so the accumulator holds.
REQ-023 DRAIN SHALL last 2 cycles; at the end of the second, capture mac_out into res_data and go to DONE.
REQ-024 Latency: res_valid SHALL rise in cycle len+3 for len>0, and in cycle 1 for len=0.
REQ-025 DONE SHALL hold res_valid=1 and res_data stable until res_ready=1 is sampled, then go to IDLE.
REQ-026 res_valid=1 with res_ready=1 in the same cycle SHALL complete the transfer; a start in that cycle SHALL be ignored and is honoured only from IDLE in a later cycle.
REQ-027 start while busy=1 SHALL be ignored; len, bases and bias SHALL only be sampled in IDLE.
REQ-028 res_data SHALL be bit-exact two's-complement SUM_WIDTH-wide: no truncation or saturation, except as stated in REQ-032.

Reset
REQ-029 rst=0 SHALL immediately force IDLE regardless of clk. Outputs: rd_en=0, busy=0, res_valid=0, res_data=0, x_addr=0, w_addr=0, mac_xin=0, mac_win=0. Term and drain counters SHALL clear.
REQ-030 rst asserted mid-ISSUE or mid-DRAIN SHALL abort the operation with no res_valid pulse. After release, the block SHALL accept a new start from IDLE.

Configuration
REQ-031 Macro MAC_SEQ_RELU_EN SHALL select whether a ReLU is compiled in.
REQ-032 With MAC_SEQ_RELU_EN defined, REQ-023 capture SHALL store 0 when mac_out is negative, else mac_out. The len=0 path SHALL apply the same rule to bias.
REQ-033 Without MAC_SEQ_RELU_EN, res_data SHALL equal mac_out (or bias) unmodified, and no ReLU logic SHALL exist.

Verification
REQ-034 len=3, x=[1,2,3], w=[4,5,6], bias=10, res_ready=1 -> res_data=42, res_valid high in cycle 6 for one cycle.
REQ-035 len=0, bias=-7 -> rd_en never asserted; res_data=-7 in cycle 1 without ReLU, and 0 with MAC_SEQ_RELU_EN.
REQ-036 len=2, x_base=255, N=32, x=[-2^31,-2^31], w=[-2^31,-2^31], bias=0:
- x_addr SHALL go 255 then 0 (wrap).
- res_data SHALL be 2^63 with no overflow.
REQ-037 res_ready held 0 for 5 cycles in DONE, start pulsed during that time -> res_valid and res_data held; start ignored; IDLE only after res_ready=1.
REQ-038 rst=0 during ISSUE of a len=8 job -> busy=0 and rd_en=0 immediately, no res_valid; a new len=1 job (x=3, w=-4, bias=0) SHALL return -12.
